// File: rtl/or1200_keccak_cop.sv
// Responder for the l.cust5 Keccak custom instruction: it collects operand words into an input block,
// launches the external permutation core, and returns the captured result words on store ops.
module or1200_keccak_cop #(
  parameter int DW        = 32,
  parameter int IN_WORDS  = 16,
  parameter int OUT_WORDS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cop_valid,
  input  logic [4:0]              cop_op,
  input  logic [5:0]              cop_idx,
  input  logic [DW-1:0]           cop_opa,
  output logic                    cop_stall,
  output logic [DW-1:0]           cop_result,
  output logic                    cop_result_valid,
  output logic                    cop_err,
  output logic [IN_WORDS*DW-1:0]  core_din,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [OUT_WORDS*DW-1:0] core_dout
);

  localparam logic [4:0] OP_START  = 5'b00100;
  localparam logic [4:0] OP_MIDDLE = 5'b00010;
  localparam logic [4:0] OP_END    = 5'b00001;
  localparam logic [4:0] OP_STORE  = 5'b01000;

  localparam int AW = $clog2(IN_WORDS);
  localparam int CW = $clog2(IN_WORDS + 1);
  localparam int RW = $clog2(OUT_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] in_buf   [IN_WORDS];
  logic [DW-1:0] result_q [OUT_WORDS];
  logic [CW-1:0] count_q;

  logic accept, buf_full, idx_ok;
  logic do_start, do_write, do_launch, do_store, err_set;
  logic [RW-1:0] ridx;

  // A command in RUN is held off until the cycle after core_done.
  assign cop_stall = (state_q == S_RUN) && cop_valid;
  assign accept    = cop_valid && !cop_stall;
  assign buf_full  = (count_q == CW'(IN_WORDS));
  assign idx_ok    = int'(cop_idx) < OUT_WORDS;
  assign ridx      = cop_idx[RW-1:0];

  for (genvar g = 0; g < IN_WORDS; g++) begin : g_din
    assign core_din[g*DW +: DW] = in_buf[g];
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    do_start  = 1'b0;
    do_write  = 1'b0;
    do_launch = 1'b0;
    do_store  = 1'b0;
    err_set   = 1'b0;
    if (state_q == S_RUN) begin
      if (core_done) state_d = S_DONE;
    end else if (accept) begin
      case (cop_op)
        OP_START: begin
          do_start = 1'b1;
          state_d  = S_ABSORB;
        end
        OP_MIDDLE: begin
          if (state_q != S_ABSORB) err_set = 1'b1;
          else if (buf_full)       err_set = 1'b1;
          else                     do_write = 1'b1;
        end
        OP_END: begin
          if (state_q != S_ABSORB) begin
            err_set = 1'b1;
          end else begin
            // An overflowing end word is dropped, but the block is still launched.
            if (buf_full) err_set  = 1'b1;
            else          do_write = 1'b1;
            do_launch = 1'b1;
            state_d   = S_RUN;
          end
        end
        OP_STORE: begin
          do_store = 1'b1;
          if (!idx_ok) err_set = 1'b1;
        end
        default: err_set = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      count_q          <= '0;
      cop_result       <= '0;
      cop_result_valid <= 1'b0;
      cop_err          <= 1'b0;
      core_start       <= 1'b0;
      // NOTE: both word arrays are cleared on reset because unwritten words must read as zero;
      // other arrays would normally be left unreset.
      for (int i = 0; i < IN_WORDS; i++)  in_buf[i]   <= '0;
      for (int i = 0; i < OUT_WORDS; i++) result_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
      state_q          <= state_d;
      core_start       <= do_launch;
      cop_result_valid <= do_store;
      if (err_set) cop_err <= 1'b1;
      if (do_store) cop_result <= idx_ok ? result_q[ridx] : '0;

      if (do_start) begin
        for (int i = 1; i < IN_WORDS; i++) in_buf[i] <= '0;
        in_buf[0] <= cop_opa;
        count_q   <= CW'(1);
      end else if (do_write) begin
        in_buf[count_q[AW-1:0]] <= cop_opa;
        count_q                 <= count_q + CW'(1);
      end

      if (state_q == S_RUN && core_done) begin
        for (int i = 0; i < OUT_WORDS; i++) result_q[i] <= core_dout[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_or1200_keccak_cop.sv
// Self-checking bench for or1200_keccak_cop: directed and random cust5 sequences compared against
// a word-queue model of the block buffer, the result words and the sticky error flag.
module tb_or1200_keccak_cop;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int OW = 16;

  localparam logic [4:0] OP_START = 5'b00100;
  localparam logic [4:0] OP_MID   = 5'b00010;
  localparam logic [4:0] OP_END   = 5'b00001;
  localparam logic [4:0] OP_STORE = 5'b01000;

  logic              clk = 1'b0;
  logic              rst;
  logic              cop_valid;
  logic [4:0]        cop_op;
  logic [5:0]        cop_idx;
  logic [DW-1:0]     cop_opa;
  logic              cop_stall;
  logic [DW-1:0]     cop_result;
  logic              cop_result_valid;
  logic              cop_err;
  logic [IW*DW-1:0]  core_din;
  logic              core_start;
  logic              core_done;
  logic [OW*DW-1:0]  core_dout;

  always #5 clk = ~clk;

  or1200_keccak_cop #(.DW(DW), .IN_WORDS(IW), .OUT_WORDS(OW)) dut (
    .clk(clk), .rst(rst),
    .cop_valid(cop_valid), .cop_op(cop_op), .cop_idx(cop_idx), .cop_opa(cop_opa),
    .cop_stall(cop_stall), .cop_result(cop_result), .cop_result_valid(cop_result_valid),
    .cop_err(cop_err), .core_din(core_din), .core_start(core_start),
    .core_done(core_done), .core_dout(core_dout)
  );

  int errors = 0;
  int checks = 0;

  // Model: the absorbed words in order, the last captured result block, the sticky error,
  // and whether a block is being absorbed or is with the core.
  logic [DW-1:0] m_words[$];
  logic [DW-1:0] m_res [OW];
  bit            m_err, m_abs, m_run;
  bit            e_rv, e_cs;
  logic [DW-1:0] e_res;

  task automatic check(input string tag, input logic [IW*DW-1:0] obs, input logic [IW*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW*DW-1:0] exp_din();
    logic [IW*DW-1:0] d = '0;
    for (int i = 0; i < IW; i++)
      if (i < m_words.size()) d[i*DW +: DW] = m_words[i];
    return d;
  endfunction

  task automatic model_reset();
    m_words.delete();
    for (int i = 0; i < OW; i++) m_res[i] = '0;
    m_err = 0; m_abs = 0; m_run = 0; e_rv = 0; e_cs = 0; e_res = '0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; cop_valid = 1'b0; core_done = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: check what the previous edge produced, present this cycle's inputs,
  // check the stall, then advance the model by this cycle's command.
  task automatic step(input bit v, input logic [4:0] op, input logic [5:0] idx,
                      input logic [DW-1:0] a, input bit done, input logic [DW-1:0] base);
    @(negedge clk);
    check("result_valid", cop_result_valid, e_rv);
    if (e_rv) check("result", cop_result, e_res);
    check("err", cop_err, m_err);
    check("core_start", core_start, e_cs);
    check("core_din", core_din, exp_din());
    cop_valid = v; cop_op = op; cop_idx = idx; cop_opa = a; core_done = done;
    for (int i = 0; i < OW; i++) core_dout[i*DW +: DW] = base + DW'(i);
    #1;
    check("stall", cop_stall, v && m_run);
    e_rv = 0; e_cs = 0;
    if (m_run) begin
      if (done) begin
        for (int i = 0; i < OW; i++) m_res[i] = base + DW'(i);
        m_run = 0;
      end
    end else if (v) begin
      case (op)
        OP_START: begin m_words.delete(); m_words.push_back(a); m_abs = 1; end
        OP_MID: begin
          if (m_abs && m_words.size() < IW) m_words.push_back(a);
          else m_err = 1;
        end
        OP_END: begin
          if (!m_abs) m_err = 1;
          else begin
            if (m_words.size() < IW) m_words.push_back(a);
            else m_err = 1;
            m_abs = 0; m_run = 1; e_cs = 1;
          end
        end
        OP_STORE: begin
          e_rv = 1;
          if (int'(idx) < OW) e_res = m_res[idx];
          else begin e_res = '0; m_err = 1; end
        end
        default: m_err = 1;
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 5'd0, 6'd0, '0, 0, '0);
  endtask

  task automatic cmd(input logic [4:0] op, input logic [5:0] idx, input logic [DW-1:0] a);
    step(1, op, idx, a, 0, '0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] base;
    logic [4:0]    jop;
    int            lat, mids;
    cop_valid = 0; cop_op = '0; cop_idx = '0; cop_opa = '0; core_done = 0; core_dout = '0; rst = 0;
    model_reset();

    // Reset, then a store before any permutation returns zero.
    do_reset(2);
    cmd(OP_STORE, 6'd5, '0);
    idle(2);

    // Three-word block, held store while running, capture, then fifteen-down-to-zero stores.
    cmd(OP_START, 6'd0, 32'd1);
    cmd(OP_MID,   6'd0, 32'd2);
    cmd(OP_END,   6'd0, 32'd3);
    idle(1);
    repeat (3) step(1, OP_STORE, 6'd0, '0, 0, '0);
    step(1, OP_STORE, 6'd0, '0, 1, 32'hA500_0000);
    step(1, OP_STORE, 6'd0, '0, 0, '0);
    for (int k = 15; k >= 0; k--) cmd(OP_STORE, 6'(k), '0);
    idle(2);

    // Seventeen words: the last middle and the end word are dropped, the block still launches.
    cmd(OP_START, 6'd0, 32'h100);
    for (int i = 1; i <= 16; i++) cmd(OP_MID, 6'd0, 32'h100 + 32'(i));
    idle(1);
    cmd(OP_END, 6'd0, 32'h200);
    idle(2);
    step(0, 5'd0, 6'd0, '0, 1, 32'h5A00_0000);
    for (int k = 0; k < 4; k++) cmd(OP_STORE, 6'(k), '0);
    cmd(OP_END, 6'd0, 32'h300);
    cmd(OP_STORE, 6'd2, '0);
    idle(1);

    // Each illegal command sets the error flag on its own.
    do_reset(1);
    cmd(5'b00011, 6'd0, 32'h1);
    idle(1);
    do_reset(1);
    cmd(OP_END, 6'd0, 32'h1);
    idle(1);
    do_reset(1);
    cmd(OP_STORE, 6'd20, '0);
    idle(1);

    // Reset during RUN; a late core_done must be ignored.
    do_reset(1);
    cmd(OP_START, 6'd0, 32'h7);
    cmd(OP_END,   6'd0, 32'h8);
    idle(1);
    step(1, OP_STORE, 6'd1, '0, 0, '0);
    do_reset(2);
    step(0, 5'd0, 6'd0, '0, 1, 32'hDEAD_0000);
    cmd(OP_STORE, 6'd1, '0);
    cmd(OP_STORE, 6'd0, '0);
    idle(1);

    // Random blocks with interleaved stores/junk ops, random core latency and result data.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 7) == 0) do_reset(1);
      cmd(OP_START, 6'd0, $urandom);
      mids = $urandom_range(0, 17);
      for (int m = 0; m < mids; m++) begin
        case ($urandom_range(0, 5))
          0: cmd(OP_STORE, 6'($urandom_range(0, 20)), '0);
          1: begin
            jop = 5'($urandom_range(0, 31));
            if (jop == OP_END || jop == OP_START) jop = 5'b10000;
            cmd(jop, 6'd0, $urandom);
          end
          2: idle(1);
          default: cmd(OP_MID, 6'd0, $urandom);
        endcase
      end
      cmd(OP_END, 6'd0, $urandom);
      lat  = $urandom_range(1, 6);
      base = $urandom;
      for (int c = 0; c < 10 && m_run; c++) begin
        step(bit'($urandom_range(0, 1)), OP_STORE, 6'($urandom_range(0, 20)), '0,
             (lat == 0), base);
        lat--;
      end
      check("run_ended", 1'(m_run), 1'b0);
      repeat ($urandom_range(1, 5)) cmd(OP_STORE, 6'($urandom_range(0, 20)), '0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
